// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package rr_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Increment modulo n, so the last requester wraps back to 0.
  function automatic int unsigned inc_mod(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Lowest-set-bit priority encoder; valid is high when any bit is set.
module priority_encoder #(
  parameter int WIDTH    = 4,
  parameter int IDX_BITS = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]    vec,
  output logic [IDX_BITS-1:0] idx,
  output logic                valid
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_BITS'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mask_select.sv
// Round-robin winner selection: lowest request at or above ptr, else wrap to lowest request.
module rr_mask_select #(
  parameter int NUM_REQS = 4,
  parameter int IDX_BITS = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [IDX_BITS-1:0] winner,
  output logic                any
);

  logic [NUM_REQS-1:0] hi_mask;
  logic [NUM_REQS-1:0] hi;
  logic [IDX_BITS-1:0] hi_idx;
  logic [IDX_BITS-1:0] lo_idx;
  logic                hi_any;
  logic                lo_any;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
  end

  assign hi = req & hi_mask;

  priority_encoder #(.WIDTH(NUM_REQS), .IDX_BITS(IDX_BITS)) u_hi_enc (
    .vec   (hi),
    .idx   (hi_idx),
    .valid (hi_any)
  );

  priority_encoder #(.WIDTH(NUM_REQS), .IDX_BITS(IDX_BITS)) u_lo_enc (
    .vec   (req),
    .idx   (lo_idx),
    .valid (lo_any)
  );

  assign winner = hi_any ? hi_idx : lo_idx;
  assign any    = lo_any;

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin arbiter that locks the grant to one requester until its tail flit
// (or a forced release at MAX_PKT_LEN flits) transfers.
module rr_packet_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int IDX_BITS    = $clog2(NUM_REQS),
  parameter int MAX_PKT_LEN = 16,
  parameter int CNT_BITS    = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQS-1:0] req,
  input  logic [NUM_REQS-1:0] req_tail,
  input  logic                out_ready,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                grant_valid,
  output logic                fire,
  output logic                len_err,
  output arb_state_t          state,
  output logic [IDX_BITS-1:0] ptr
);

  // Handshake: a flit moves on a cycle where grant_valid, the granted requester's
  // req and out_ready are all high; nothing else may advance the packet.

  arb_state_t          state_d;
  logic [NUM_REQS-1:0] grant_d;
  logic [IDX_BITS-1:0] grant_idx_d;
  logic [IDX_BITS-1:0] ptr_d;
  logic [IDX_BITS-1:0] nxt_ptr;
  logic [CNT_BITS-1:0] flit_cnt;
  logic [CNT_BITS-1:0] flit_cnt_d;
  logic                len_err_d;
  logic [NUM_REQS-1:0] sel_req;
  logic [IDX_BITS-1:0] sel_ptr;
  logic [IDX_BITS-1:0] winner;
  logic                any_req;
  logic                is_tail;
  logic                last_flit;
  logic                release_now;

  assign grant_valid = (state == ARB_LOCKED);
  assign fire        = grant_valid & (|(grant & req)) & out_ready;
  assign is_tail     = |(grant & req_tail);
  assign last_flit   = (flit_cnt == CNT_BITS'(MAX_PKT_LEN - 1));
  assign release_now = fire & (is_tail | last_flit);
  assign nxt_ptr     = IDX_BITS'(inc_mod(32'(grant_idx), NUM_REQS));

  // While locked the selector only matters on release: evaluate with the advanced
  // pointer and the releasing requester removed so a new lock follows with no bubble.
  assign sel_ptr = grant_valid ? nxt_ptr : ptr;
  assign sel_req = grant_valid ? (req & ~grant) : req;

  rr_mask_select #(.NUM_REQS(NUM_REQS), .IDX_BITS(IDX_BITS)) u_select (
    .req    (sel_req),
    .ptr    (sel_ptr),
    .winner (winner),
    .any    (any_req)
  );

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    grant_idx_d = grant_idx;
    ptr_d       = ptr;
    flit_cnt_d  = flit_cnt;
    len_err_d   = len_err;
    unique case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_d     = ARB_LOCKED;
          grant_d     = NUM_REQS'(1) << winner;
          grant_idx_d = winner;
          flit_cnt_d  = '0;
        end
      end
      ARB_LOCKED: begin
        if (fire) begin
          flit_cnt_d = flit_cnt + 1'b1;
        end
        if (release_now) begin
          ptr_d = nxt_ptr;
          if (!is_tail) begin
            len_err_d = 1'b1;
          end
          flit_cnt_d = '0;
          if (any_req) begin
            grant_d     = NUM_REQS'(1) << winner;
            grant_idx_d = winner;
          end else begin
            state_d     = ARB_IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
          end
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        grant_d     = '0;
        grant_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      flit_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      grant_idx <= grant_idx_d;
      ptr       <= ptr_d;
      flit_cnt  <= flit_cnt_d;
      len_err   <= len_err_d;
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed table-driven bench for rr_packet_arbiter (N=4, MAX_PKT_LEN=4).
module tb_rr_packet_arbiter;
  import rr_arb_pkg::*;

  localparam int N   = 4;
  localparam int IDX = 2;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_tail;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic [IDX-1:0] grant_idx;
  logic           grant_valid;
  logic           fire;
  logic           len_err;
  arb_state_t     state;
  logic [IDX-1:0] ptr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   tail;
    logic           rdy;
    logic           exp_fire;
    logic [N-1:0]   exp_grant;
    logic [IDX-1:0] exp_idx;
    logic           exp_valid;
    logic           exp_len_err;
    logic [IDX-1:0] exp_ptr;
  } vec_t;

  vec_t vec_q[$];

  rr_packet_arbiter #(.NUM_REQS(N), .MAX_PKT_LEN(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_tail    (req_tail),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .fire        (fire),
    .len_err     (len_err),
    .state       (state),
    .ptr         (ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst_n, input logic [N-1:0] rq, input logic [N-1:0] tl,
                              input logic rdy, input logic f, input logic [N-1:0] g,
                              input logic [IDX-1:0] ix, input logic v, input logic le,
                              input logic [IDX-1:0] p);
    vec_t r;
    r.rst_n = rst_n; r.req = rq; r.tail = tl; r.rdy = rdy; r.exp_fire = f;
    r.exp_grant = g; r.exp_idx = ix; r.exp_valid = v; r.exp_len_err = le; r.exp_ptr = p;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: present one row, check combinational fire, clock it, check registered outputs.
  task automatic apply(input vec_t v, input string tag);
    reset_n   = v.rst_n;
    req       = v.req;
    req_tail  = v.tail;
    out_ready = v.rdy;
    #1;
    if (v.rst_n) check({tag, ".fire"}, 32'(fire), 32'(v.exp_fire));
    @(posedge clk);
    #1;
    check({tag, ".grant"}, 32'(grant), 32'(v.exp_grant));
    check({tag, ".grant_idx"}, 32'(grant_idx), 32'(v.exp_idx));
    check({tag, ".grant_valid"}, 32'(grant_valid), 32'(v.exp_valid));
    check({tag, ".len_err"}, 32'(len_err), 32'(v.exp_len_err));
    check({tag, ".ptr"}, 32'(ptr), 32'(v.exp_ptr));
    check({tag, ".state"}, 32'(state), 32'(v.exp_valid ? ARB_LOCKED : ARB_IDLE));
  endtask

  initial begin
    reset_n = 1'b0; req = '0; req_tail = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    // Reset state (second reset edge, checked through the common row path).
    apply(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0), "reset");

    //        rst req      tail     rdy fire grant    idx v  le ptr
    // Single-flit on requester 2, then idle; pointer moves to 3.
    vec_q.push_back(mk(1, 4'b0100, 4'b0100, 1, 0, 4'b0100, 2, 1, 0, 0));
    vec_q.push_back(mk(1, 4'b0100, 4'b0100, 1, 1, 4'b0000, 0, 0, 0, 3));
    // Wrap-around from ptr=3; tail fire hands over to requester 1 with ptr=1.
    vec_q.push_back(mk(1, 4'b0011, 4'b0011, 0, 0, 4'b0001, 0, 1, 0, 3));
    vec_q.push_back(mk(1, 4'b0011, 4'b0011, 1, 1, 4'b0010, 1, 1, 0, 1));
    // 3-flit packet on requester 1 with out_ready 1,0,1,1 under full load.
    vec_q.push_back(mk(1, 4'b1111, 4'b0000, 1, 1, 4'b0010, 1, 1, 0, 1));
    vec_q.push_back(mk(1, 4'b1111, 4'b0000, 0, 0, 4'b0010, 1, 1, 0, 1));
    vec_q.push_back(mk(1, 4'b1111, 4'b0000, 1, 1, 4'b0010, 1, 1, 0, 1));
    vec_q.push_back(mk(1, 4'b1111, 4'b0010, 1, 1, 4'b0100, 2, 1, 0, 2));
    // Granted requester drops its request: grant holds, no fire.
    vec_q.push_back(mk(1, 4'b1011, 4'b0000, 1, 0, 4'b0100, 2, 1, 0, 2));
    // Fairness with all single-flit: 1000, 0001, 0010, 0100, 1000, 0001.
    vec_q.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 4'b1000, 3, 1, 0, 3));
    vec_q.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 4'b0001, 0, 1, 0, 0));
    vec_q.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 4'b0010, 1, 1, 0, 1));
    vec_q.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 4'b0100, 2, 1, 0, 2));
    vec_q.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 4'b1000, 3, 1, 0, 3));
    vec_q.push_back(mk(1, 4'b1111, 4'b1111, 1, 1, 4'b0001, 0, 1, 0, 0));
    // Lone releasing requester goes through IDLE before being re-granted.
    vec_q.push_back(mk(1, 4'b0001, 4'b0001, 1, 1, 4'b0000, 0, 0, 0, 1));
    vec_q.push_back(mk(1, 4'b0001, 4'b0001, 1, 0, 4'b0001, 0, 1, 0, 1));
    // No tail ever: forced release on the 4th fire sets len_err.
    vec_q.push_back(mk(1, 4'b0001, 4'b0000, 1, 1, 4'b0001, 0, 1, 0, 1));
    vec_q.push_back(mk(1, 4'b0001, 4'b0000, 1, 1, 4'b0001, 0, 1, 0, 1));
    vec_q.push_back(mk(1, 4'b0001, 4'b0000, 1, 1, 4'b0001, 0, 1, 0, 1));
    vec_q.push_back(mk(1, 4'b0001, 4'b0000, 1, 1, 4'b0000, 0, 0, 1, 1));
    // len_err is sticky across later traffic.
    vec_q.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 1));
    vec_q.push_back(mk(1, 4'b0100, 4'b0100, 1, 0, 4'b0100, 2, 1, 1, 1));
    vec_q.push_back(mk(1, 4'b0100, 4'b0100, 1, 1, 4'b0000, 0, 0, 1, 3));

    foreach (vec_q[i]) apply(vec_q[i], $sformatf("row%0d", i));

    // Reset mid-packet: lock requester 1 (ptr=3 wraps to 1), move one flit, then reset.
    apply(mk(1, 4'b0010, 4'b0000, 1, 0, 4'b0010, 1, 1, 1, 3), "mid.lock");
    apply(mk(1, 4'b0010, 4'b0000, 1, 1, 4'b0010, 1, 1, 1, 3), "mid.flit");
    apply(mk(0, 4'b0010, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0), "mid.reset");
    // From ptr=0 requester 1 wins over 3; a stale ptr=3 would pick 3.
    apply(mk(1, 4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 1, 0, 0), "mid.rearb");
    // The reset dropped the partial count: 3 more fires do not force a release.
    apply(mk(1, 4'b1010, 4'b0000, 1, 1, 4'b0010, 1, 1, 0, 0), "mid.cnt1");
    apply(mk(1, 4'b1010, 4'b0000, 1, 1, 4'b0010, 1, 1, 0, 0), "mid.cnt2");
    apply(mk(1, 4'b1010, 4'b0000, 1, 1, 4'b0010, 1, 1, 0, 0), "mid.cnt3");
    apply(mk(1, 4'b1010, 4'b0000, 1, 1, 4'b1000, 3, 1, 1, 2), "mid.cnt4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
